// File: rtl/spi_flash_defs.sv
// Shared constants, state type and command/byte-order helpers for the
// EN25F80 read-only SPI flash controller.
package spi_flash_defs;

  localparam logic [7:0]  SPI_OP_READ   = 8'h03;
  localparam int unsigned SPI_XFER_BITS = 64;
  localparam int unsigned SPI_DATA_BITS = 32;
  localparam int unsigned BIT_CNT_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_t;

  // Opcode + 24-bit flash byte address, sent MSB first.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  pad;
    logic [17:0] word_addr;
    logic [1:0]  byte_sel;
  } spi_cmd_t;

  function automatic logic [SPI_XFER_BITS-1:0] build_read_cmd(input logic [17:0] word_addr);
    spi_cmd_t cmd;
    cmd.opcode    = SPI_OP_READ;
    cmd.pad       = 4'h0;
    cmd.word_addr = word_addr;
    cmd.byte_sel  = 2'b00;
    return {cmd, {SPI_DATA_BITS{1'b0}}};
  endfunction

  // First byte received sits in the MSBs; the CPU wants it in the LSBs.
  function automatic logic [SPI_DATA_BITS-1:0] le_word(input logic [SPI_DATA_BITS-1:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 bit engine: SCK phase generation, 64-bit TX shift-out and
// 32-bit RX shift-in, controlled by a start/abort/done handshake.
module spi_shifter
  import spi_flash_defs::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [SPI_XFER_BITS-1:0] i_tx,
  input  logic                     i_miso,
  output logic                     o_sck,
  output logic                     o_cs_n,
  output logic                     o_mosi,
  output logic [SPI_DATA_BITS-1:0] o_rx,
  output logic                     o_done_c
);

  localparam int unsigned          PH_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0]      PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SPI_XFER_BITS - 1);

  logic                     r_active;
  logic                     r_sck;
  logic                     r_cs_n;
  logic [PH_W-1:0]          r_phase;
  logic [BIT_CNT_W-1:0]     r_bit;
  logic [SPI_XFER_BITS-1:0] r_tx;
  logic [SPI_DATA_BITS-1:0] r_rx;
  logic                     w_edge;

  // w_edge marks the last clk of a half-period, where SCK toggles.
  assign w_edge   = r_active && (r_phase == PH_LAST);
  assign o_done_c = w_edge && r_sck && (r_bit == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_active <= 1'b0;
      r_sck    <= 1'b0;
      r_cs_n   <= 1'b1;
      r_phase  <= '0;
      r_bit    <= '0;
      r_tx     <= '0;
      if (rst) begin
        r_rx <= '0;
      end
    end else if (i_start) begin
      r_active <= 1'b1;
      r_sck    <= 1'b0;
      r_cs_n   <= 1'b0;
      r_phase  <= '0;
      r_bit    <= '0;
      r_tx     <= i_tx;
    end else if (r_active) begin
      r_phase <= w_edge ? '0 : r_phase + PH_W'(1);
      if (w_edge) begin
        r_sck <= ~r_sck;
        if (!r_sck) begin
          r_rx <= {r_rx[SPI_DATA_BITS-2:0], i_miso};
        end else begin
          // TX advances with the falling edge so MOSI holds a full low phase.
          r_tx <= r_tx << 1;
          if (r_bit == LAST_BIT) begin
            r_active <= 1'b0;
            r_cs_n   <= 1'b1;
          end else begin
            r_bit <= r_bit + BIT_CNT_W'(1);
          end
        end
      end
    end
  end

  assign o_sck  = r_sck;
  assign o_cs_n = r_cs_n;
  assign o_mosi = r_tx[SPI_XFER_BITS-1];
  assign o_rx   = r_rx;

endmodule

// File: rtl/spi_flash_ctrl.sv
// CPU device-bus front end for the EN25F80: turns a word read into an SPI
// READ transaction and returns the little-endian word.
module spi_flash_ctrl
  import spi_flash_defs::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        devEnable_i,
  input  logic        readEnable_i,
  input  logic [31:0] addr_i,
  output logic [31:0] readData_o,
  output logic        busy_o,
  output logic        spiClk_o,
  output logic        spiCs_n_o,
  output logic        spiDi_o,
  input  logic        spiDo_i
);

  localparam int unsigned      GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [GAP_W-1:0]         r_gap;
  logic [31:0]              r_rdata;
  logic                     w_req;
  logic                     w_start;
  logic                     w_abort;
  logic                     w_done;
  logic                     w_busy;
  logic [SPI_DATA_BITS-1:0] w_rx;
  logic                     w_unused_addr;

  assign w_req         = devEnable_i & readEnable_i;
  assign w_unused_addr = ^{addr_i[31:20], addr_i[1:0]};

  spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_abort  (w_abort),
    .i_tx     (build_read_cmd(addr_i[19:2])),
    .i_miso   (spiDo_i),
    .o_sck    (spiClk_o),
    .o_cs_n   (spiCs_n_o),
    .o_mosi   (spiDi_o),
    .o_rx     (w_rx),
    .o_done_c (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, shifter handshake and stall request.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = w_req;
        if (w_req) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_busy = 1'b1;
        if (!devEnable_i) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_GAP;
        end else if (w_done) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        w_busy = w_req;
        if (r_gap == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_GAP)) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + GAP_W'(1);
    end
  end

  // Data is captured on the last SCK-high cycle so it is valid in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if ((r_state == ST_SHIFT) && devEnable_i && w_done) begin
      r_rdata <= le_word(w_rx);
    end
  end

  assign busy_o     = w_busy & ~rst;
  assign readData_o = r_rdata;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Randomised and directed bench for spi_flash_ctrl: a flash slave model plus
// a transaction-level expectation model checked every cycle.
module tb_spi_flash_ctrl;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned CS_GAP   = 4;
  localparam int          BIT_CYC  = 2 * CLK_DIV;
  localparam int          XFER_CYC = 64 * BIT_CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        devEnable_i = 1'b0;
  logic        readEnable_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] readData_o;
  logic        busy_o;
  logic        spiClk_o;
  logic        spiCs_n_o;
  logic        spiDi_o;
  logic        spiDo_i = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  spi_flash_ctrl #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .devEnable_i  (devEnable_i),
    .readEnable_i (readEnable_i),
    .addr_i       (addr_i),
    .readData_o   (readData_o),
    .busy_o       (busy_o),
    .spiClk_o     (spiClk_o),
    .spiCs_n_o    (spiCs_n_o),
    .spiDi_o      (spiDi_o),
    .spiDo_i      (spiDo_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Flash contents: a known word at 0x104, a deterministic pattern elsewhere.
  function automatic logic [7:0] mem_byte(input logic [19:0] a);
    case (a)
      20'h00104: return 8'h11;
      20'h00105: return 8'h22;
      20'h00106: return 8'h33;
      20'h00107: return 8'h44;
      default:   return 8'(a[7:0] * 8'd13) ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [19:0] a;
    a = {addr[19:2], 2'b00};
    return {mem_byte(20'(a + 20'd3)), mem_byte(20'(a + 20'd2)),
            mem_byte(20'(a + 20'd1)), mem_byte(a)};
  endfunction

  // SPI slave: captures opcode/address on SCK rise, drives data on SCK fall.
  int          fl_cnt = 0;
  logic [31:0] fl_cmd = '0;

  always @(negedge spiCs_n_o) fl_cnt = 0;

  always @(posedge spiClk_o) begin
    if (spiCs_n_o == 1'b0) begin
      if (fl_cnt < 32) fl_cmd = {fl_cmd[30:0], spiDi_o};
      fl_cnt = fl_cnt + 1;
    end
  end

  always @(negedge spiClk_o) begin : fl_drive
    int         idx;
    logic [7:0] b;
    if (fl_cnt >= 32 && fl_cnt < 64) begin
      idx     = fl_cnt - 32;
      b       = mem_byte(20'(fl_cmd[19:0] + 20'(idx / 8)));
      spiDo_i = b[3'(7 - idx % 8)];
    end
  end

  // Transaction-level expectation model, advanced at each rising clk edge.
  typedef enum int {M_IDLE, M_XFER, M_DONE, M_GAP} mmode_t;
  mmode_t      m_mode = M_IDLE;
  int          m_t = 0;
  int          m_gap = 0;
  logic [63:0] m_cmd = '0;
  logic [31:0] m_word = '0;
  logic [31:0] m_rd = '0;
  bit          m_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE;
      m_rd   = '0;
      m_on   = 1'b1;
    end else if (m_on) begin
      case (m_mode)
        M_IDLE: if (devEnable_i && readEnable_i) begin
          m_mode = M_XFER;
          m_t    = 0;
          m_cmd  = {8'h03, 4'h0, addr_i[19:2], 2'b00, 32'h0};
          m_word = mem_word(addr_i);
        end
        M_XFER: begin
          if (!devEnable_i) begin
            m_mode = M_GAP;
            m_gap  = CS_GAP;
          end else if (m_t == XFER_CYC - 1) begin
            m_mode = M_DONE;
            m_rd   = m_word;
          end else begin
            m_t++;
          end
        end
        M_DONE: begin
          m_mode = M_GAP;
          m_gap  = CS_GAP;
        end
        default: begin
          m_gap--;
          if (m_gap == 0) m_mode = M_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    logic e_cs, e_sck, e_di, e_busy;
    if (m_on) begin
      e_cs   = 1'b1;
      e_sck  = 1'b0;
      e_di   = 1'b0;
      e_busy = 1'b0;
      case (m_mode)
        M_XFER: begin
          e_cs   = 1'b0;
          e_sck  = (m_t % BIT_CYC) >= CLK_DIV;
          e_di   = m_cmd[6'(63 - m_t / BIT_CYC)];
          e_busy = 1'b1;
        end
        M_IDLE, M_GAP: e_busy = devEnable_i & readEnable_i;
        default: ;
      endcase
      if (rst) e_busy = 1'b0;
      check("cs_n", 32'(spiCs_n_o), 32'(e_cs));
      check("sck", 32'(spiClk_o), 32'(e_sck));
      check("mosi", 32'(spiDi_o), 32'(e_di));
      check("busy", 32'(busy_o), 32'(e_busy));
      check("readData", readData_o, m_rd);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Holds current inputs; returns in the first cycle busy_o is low.
  task automatic wait_busy_low(output int busy_cyc);
    int n;
    busy_cyc = 0;
    for (n = 0; n < 600; n++) begin
      #1;
      if (!busy_o) break;
      busy_cyc++;
      cyc();
    end
    if (n >= 600) check("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic read_word(input logic [31:0] a, output int busy_cyc, output logic [31:0] data);
    devEnable_i  = 1'b1;
    readEnable_i = 1'b1;
    addr_i       = a;
    wait_busy_low(busy_cyc);
    data         = readData_o;
    devEnable_i  = 1'b0;
    readEnable_i = 1'b0;
  endtask

  initial begin
    int          bc;
    int          cnt_a;
    int          cnt_b;
    int          sel;
    logic [31:0] d;
    logic [31:0] ra;

    cyc(3);
    rst = 1'b0;
    #1;
    check("reset_cs_n", 32'(spiCs_n_o), 32'd1);
    check("reset_sck", 32'(spiClk_o), 32'd0);
    check("reset_rdata", readData_o, 32'h0);
    cyc(2);

    read_word(32'h0000_0104, bc, d);
    check("rd104_busy_cycles", 32'(bc), 32'd257);
    check("rd104_data", d, 32'h4433_2211);
    check("rd104_cmd", fl_cmd, 32'h0300_0104);
    cyc(CS_GAP + 2);

    read_word(32'hBFC0_0013, bc, d);
    check("rdBFC_cmd", fl_cmd, 32'h0300_0010);
    check("rdBFC_busy_cycles", 32'(bc), 32'd257);
    cyc(CS_GAP + 2);

    read_word(32'h0000_0107, bc, d);
    check("rd107_cmd", fl_cmd, 32'h0300_0104);
    check("rd107_data", d, 32'h4433_2211);
    cyc(CS_GAP + 2);

    // Write request: no stall, no SPI activity, data untouched.
    devEnable_i  = 1'b1;
    readEnable_i = 1'b0;
    addr_i       = 32'h0000_0104;
    cnt_a = 0;
    cnt_b = 0;
    repeat (40) begin
      #1;
      if (!spiCs_n_o) cnt_a++;
      if (busy_o) cnt_b++;
      cyc();
    end
    devEnable_i = 1'b0;
    check("wr_cs_low_cycles", 32'(cnt_a), 32'd0);
    check("wr_busy_cycles", 32'(cnt_b), 32'd0);
    check("wr_rdata", readData_o, 32'h4433_2211);
    cyc(2);

    // Back-to-back reads with the request held through GAP.
    devEnable_i  = 1'b1;
    readEnable_i = 1'b1;
    addr_i       = 32'h0000_0000;
    wait_busy_low(bc);
    check("b2b_first_data", readData_o, 32'h82BF_A8A5);
    addr_i = 32'h0000_0004;
    cnt_a  = 0;
    for (int n = 0; n < 50; n++) begin
      if (!spiCs_n_o) break;
      cnt_a++;
      cyc();
      #1;
    end
    check("b2b_cs_high_ge_gap", 32'(cnt_a >= int'(CS_GAP + 1)), 32'd1);
    wait_busy_low(bc);
    check("b2b_second_data", readData_o, 32'hFEEB_E491);
    devEnable_i  = 1'b0;
    readEnable_i = 1'b0;
    cyc(CS_GAP + 2);

    // Reset during bit 20.
    devEnable_i  = 1'b1;
    readEnable_i = 1'b1;
    addr_i       = 32'h0000_0104;
    cyc(1 + BIT_CYC * 20);
    rst = 1'b1;
    #1;
    check("rst_busy_low", 32'(busy_o), 32'd0);
    cyc();
    rst          = 1'b0;
    devEnable_i  = 1'b0;
    readEnable_i = 1'b0;
    #1;
    check("rst_cs_n", 32'(spiCs_n_o), 32'd1);
    check("rst_sck", 32'(spiClk_o), 32'd0);
    check("rst_mosi", 32'(spiDi_o), 32'd0);
    check("rst_rdata", readData_o, 32'h0);
    cyc(2);
    read_word(32'h0000_0104, bc, d);
    check("post_rst_data", d, 32'h4433_2211);
    check("post_rst_busy_cycles", 32'(bc), 32'd257);
    cyc(CS_GAP + 2);

    // Abort by dropping devEnable_i at bit 40.
    devEnable_i  = 1'b1;
    readEnable_i = 1'b1;
    addr_i       = 32'h0000_0008;
    cyc(1 + BIT_CYC * 40);
    devEnable_i = 1'b0;
    cyc();
    readEnable_i = 1'b0;
    #1;
    check("abort_cs_n", 32'(spiCs_n_o), 32'd1);
    check("abort_sck", 32'(spiClk_o), 32'd0);
    check("abort_rdata", readData_o, 32'h4433_2211);
    cyc(CS_GAP + 2);
    read_word(32'h0000_0008, bc, d);
    check("post_abort_data", d, 32'h2A27_D0CD);
    cyc(CS_GAP + 2);

    // Random mix of reads, writes, aborts and resets.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 99);
      ra  = $urandom;
      if (sel < 60) begin
        read_word(ra, bc, d);
      end else if (sel < 75) begin
        devEnable_i  = 1'b1;
        readEnable_i = 1'b0;
        addr_i       = ra;
        cyc($urandom_range(1, 10));
        devEnable_i  = 1'b0;
      end else if (sel < 90) begin
        devEnable_i  = 1'b1;
        readEnable_i = 1'b1;
        addr_i       = ra;
        cyc($urandom_range(2, 250));
        devEnable_i  = 1'b0;
        readEnable_i = 1'b0;
      end else begin
        devEnable_i  = 1'b1;
        readEnable_i = 1'b1;
        addr_i       = ra;
        cyc($urandom_range(2, 250));
        rst          = 1'b1;
        devEnable_i  = 1'b0;
        readEnable_i = 1'b0;
        cyc($urandom_range(1, 2));
        rst = 1'b0;
      end
      cyc($urandom_range(1, 8));
    end

    cyc(CS_GAP + 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_flash_ctrl.md
# spi_flash_ctrl

Read-only controller for the on-board EN25F80 SPI NOR flash. It turns a word read from the CPU device bus into a standard SPI READ (0x03) transaction and returns a little-endian 32-bit word. It sits beside the other device controllers: devctrl drives `devEnable_i`/`readEnable_i`, and the SPI pins go straight to the top-level `spi_clk`/`spi_cs_n`/`spi_di`/`spi_do` ports.

## Interface
Parameters:
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles (25 MHz / (2·2) = 6.25 MHz); legal ≥1.
- `CS_GAP`, default 4: minimum `clk` cycles `spiCs_n_o` stays high between transactions (≥100 ns tCSH).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (clkMain, 25 MHz)
- `rst` in 1: synchronous, active-high reset
- `devEnable_i` in 1: device selected by devctrl
- `readEnable_i` in 1: access is a read
- `addr_i` in 32: physical byte address; only [19:2] used
- `readData_o` out 32: last word read, registered
- `busy_o` out 1: CPU must stall while high
- `spiClk_o` out 1: SCK, SPI mode 0
- `spiCs_n_o` out 1: chip select, active low
- `spiDi_o` out 1: MOSI (CPU → flash)
- `spiDo_i` in 1: MISO (flash → CPU)

## Operation
- States: IDLE, SHIFT, DONE, GAP.
- IDLE: `busy_o = devEnable_i & readEnable_i` (combinational). On a request, latch `{8'h03, 4'h0, addr_i[19:2], 2'b00}` into a 64-bit TX shift register. Clear the bit counter. Go to SHIFT.
- SHIFT: 64 bit periods of 2·CLK_DIV cycles each. `spiCs_n_o` = 0.
  - Low phase (CLK_DIV cycles): SCK = 0; `spiDi_o` = TX MSB.
  - High phase (CLK_DIV cycles): SCK = 1.
  - On the cycle SCK rises, shift `spiDo_i` into the RX register.
  - On the cycle SCK falls, shift TX left.
  - Bits 0–31 are opcode and address; MISO is ignored. Bits 32–63 are data, MSB-first per byte.
  - After bit 63's high phase, go to DONE.
- DONE (1 cycle): `readData_o` ← {b3,b2,b1,b0}, where b0 is the first data byte received (byte at addr). `busy_o` = 0. `spiCs_n_o` = 1. Go to GAP.
- GAP: `spiCs_n_o` = 1 for CS_GAP cycles. `busy_o = devEnable_i & readEnable_i`. Then go to IDLE. A request pending during GAP is serviced from IDLE.
- Write requests (`readEnable_i` = 0) are ignored: `busy_o` = 0, no SPI activity, `readData_o` unchanged.
- `devEnable_i` low during SHIFT: abort. `spiCs_n_o` goes to 1 and SCK to 0 next cycle, then GAP. `readData_o` is unchanged.
- Reset, including mid-transfer: next cycle state = IDLE, `spiCs_n_o` = 1, `spiClk_o` = 0, `spiDi_o` = 0, `readData_o` = 0, counters = 0. `busy_o` = 0 while `rst` is high.

## Timing
- All SPI outputs are registered; no glitches on SCK or CS.
- Request seen in IDLE at cycle 0 → CS low from cycle 1 → DONE at cycle 1 + 128·CLK_DIV. That is cycle 257 for CLK_DIV = 2, where `busy_o` = 0 and `readData_o` is valid.
- `spiDi_o` is stable ≥ CLK_DIV cycles before each SCK rise.
- MISO is sampled at SCK rise, which is one half-period after the flash's falling-edge update.
- `spiCs_n_o` falls ≥ CLK_DIV cycles before the first SCK rise. It rises ≥ CLK_DIV cycles after the last SCK rise.
- Back-to-back reads: CS high ≥ CS_GAP + 1 cycles between transactions.
- Bit counter is 6 bits and terminates at 63. The phase counter wraps at CLK_DIV − 1.

## Structure
- Package `spi_flash_defs`: opcode `SPI_OP_READ = 8'h03`, state enum, `SPI_XFER_BITS = 64`, `SPI_DATA_BITS = 32`.
- Sub-module `spi_shifter`: SCK phase generation plus TX/RX shift registers, with start/abort/done handshake. `spi_flash_ctrl` keeps the FSM, bus handshake, byte reordering and the GAP counter.

## Test plan
- Flash model holds bytes 11 22 33 44 at 0x000104; read `addr_i` = 0x00000104. Expect: MOSI 03 00 01 04; `readData_o` = 0x44332211 in cycle 257; `busy_o` high for cycles 0–256.
- `addr_i` = 0xBFC00013 → flash address 0x000010 sent. `addr_i` = 0x00000107 → 0x000104 sent (word aligned).
- Write (`devEnable_i` = 1, `readEnable_i` = 0) → `busy_o` = 0; `spiCs_n_o` stays 1 for the whole test window.
- Two consecutive reads (0x0, 0x4) → two correct words; CS high ≥ 5 cycles between transactions; the second `busy_o` stays high through GAP.
- Assert `rst` during bit 20 → next cycle `spiCs_n_o` = 1, `spiClk_o` = 0, `readData_o` = 0, `busy_o` = 0. A subsequent read completes normally.
- Drop `devEnable_i` at bit 40 → abort: CS high next cycle, `readData_o` unchanged. The following read returns correct data.
